im_ahb_slave: RTL and testbench
===============================

IM_AHB_SLAVE -- requirements
Module: im_ahb_slave

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte base address of instruction memory.
REQ-002 Parameter ADDR_WIDTH, 14, SRAM word-address width (2^14 words = 64 KB).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 HSel  input  1  slave select from bus decoder.
REQ-006 HAddress  input  32  AHB address-phase byte address.
REQ-007 HTrans  input  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 HWrite  input  1  1 = write, 0 = read.
REQ-009 HSize  input  3  000 byte, 001 half, 010 word.
REQ-010 HWrite_data  input  32  write data, valid in data phase.
REQ-011 HReady  input  1  bus-level ready; previous transfer complete.
REQ-012 HReadyOut  output  1  this slave's data-phase ready.
REQ-013 HResp  output  2  00 OKAY, 01 ERROR.
REQ-014 HRead_data  output  32  read data, valid when HReadyOut=1 in read data phase.
REQ-015 IM_CS  output  1  SRAM chip select, active-high.
REQ-016 IM_WE  output  4  SRAM byte write enables, active-high, bit n = byte lane n.
REQ-017 IM_A  output  ADDR_WIDTH  SRAM word address.
REQ-018 IM_DI  output  32  SRAM write data.
REQ-019 IM_DO  input  32  SRAM read data, valid one cycle after a read is issued.

Function
REQ-020 Transfer accepted when HSel=1, HReady=1, HTrans[1]=1; BUSY/IDLE accepted with OKAY, zero wait, no SRAM access.
REQ-021 On acceptance, register word address (HAddress-BASE_ADDR)[ADDR_WIDTH+1:2], HWrite, HSize, HAddress[1:0].
REQ-022 States: IDLE, RD_DATA, WR_DATA, STALL_RD, ERR1, ERR2.
REQ-023 Read accepted in IDLE/RD_DATA: SRAM read issued combinationally same cycle (IM_CS=1, IM_WE=0, IM_A from HAddress); next state RD_DATA.
REQ-024 RD_DATA: HReadyOut=1, HRead_data=IM_DO; zero wait states; back-to-back reads pipelined.
REQ-025 Write accepted: next state WR_DATA; WR_DATA: IM_CS=1, IM_A=registered address, IM_DI=HWrite_data, HReadyOut=1.
REQ-026 IM_WE: word = 1111; half = 0011 or 1100 by addr[1]; byte = 0001<<addr[1:0].
REQ-027 Read accepted while in WR_DATA (port conflict): no read issued; next state STALL_RD.
REQ-028 STALL_RD: read issued from registered address, HReadyOut=0; next state RD_DATA; read-after-write latency = 1 wait state; data reflects the just-written bytes.
REQ-029 Write accepted while in RD_DATA or WR_DATA: next state WR_DATA, no wait.
REQ-030 No transfer accepted: next state IDLE; IDLE drives HReadyOut=1, HResp=00, IM_CS=0, IM_WE=0.
REQ-031 HRead_data = 0 in every state except RD_DATA.
REQ-032 HReadyOut=0 only in STALL_RD and ERR1.

Reset
REQ-033 rst=0 at clock edge: state IDLE, registered address/control cleared, HReadyOut=1, HResp=00, HRead_data=0, IM_CS=0, IM_WE=0, IM_A=0, IM_DI=0.
REQ-034 Reset mid-transfer abandons it; no SRAM write occurs in the first cycle after reset deasserts.

Configuration
REQ-035 Macro IM_AHB_SLAVE_ERR_EN defined: accepted transfer with address outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH) or HSize>010 goes ERR1 (HReadyOut=0, HResp=01) then ERR2 (HReadyOut=1, HResp=01) then IDLE; no SRAM access; transfers offered during ERR1 ignored.
REQ-036 Macro undefined: upper address bits ignored (address wraps modulo 2^(ADDR_WIDTH+2)), HSize>010 treated as word, HResp constant 00, ERR1/ERR2 unreachable.

Verification
REQ-037 Word write 0x0000_0040 data 0xDEADBEEF then read 0x40 -> IM_WE=1111, IM_A=0x010; read has one STALL_RD wait, HRead_data=0xDEADBEEF.
REQ-038 Byte write 0xA5 to 0x0000_0043 over word 0x11223344, read 0x40 -> IM_WE=1000, HRead_data=0xA5223344.
REQ-039 Four back-to-back SEQ reads 0x100..0x10C -> HReadyOut=1 every cycle, data returned in consecutive cycles.
REQ-040 With IM_AHB_SLAVE_ERR_EN, read 0x0001_0000 -> HReadyOut 0 then 1, HResp=01 both cycles, IM_CS=0; without macro, same read returns word 0.
REQ-041 rst=0 asserted during WR_DATA of write to 0x20 -> cycle after release IM_WE=0, HReadyOut=1, later read 0x20 returns prior contents.
REQ-042 HTrans=BUSY with HSel=1 -> HResp=00, HReadyOut=1, IM_CS=0.

Source files
------------

// File: rtl/im_ahb_slave.sv
// AHB-Lite slave fronting a single-port instruction SRAM with zero-wait reads and writes.
// Define IM_AHB_SLAVE_ERR_EN to answer out-of-range addresses and HSize > word with an ERROR response.
module im_ahb_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSel,
  input  logic [31:0]           HAddress,
  input  logic [1:0]            HTrans,
  input  logic                  HWrite,
  input  logic [2:0]            HSize,
  input  logic [31:0]           HWrite_data,
  input  logic                  HReady,
  output logic                  HReadyOut,
  output logic [1:0]            HResp,
  output logic [31:0]           HRead_data,
  output logic                  IM_CS,
  output logic [3:0]            IM_WE,
  output logic [ADDR_WIDTH-1:0] IM_A,
  output logic [31:0]           IM_DI,
  input  logic [31:0]           IM_DO
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_DATA  = 3'd1,
    WR_DATA  = 3'd2,
    STALL_RD = 3'd3,
    ERR1     = 3'd4,
    ERR2     = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            lane_q, lane_d;

  logic [31:0]           addrOff;
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic                  accept;
  logic                  xferErr;
  logic                  issueRead;
  logic [3:0]            wrEnables;

  assign addrOff  = HAddress - BASE_ADDR;
  assign wordAddr = addrOff[ADDR_WIDTH+1:2];
  assign accept   = rst & HSel & HReady & HTrans[1];

`ifdef IM_AHB_SLAVE_ERR_EN
  // Subtraction wraps below BASE_ADDR, so any set upper offset bit means out of range.
  assign xferErr = (addrOff[31:ADDR_WIDTH+2] != '0) || (HSize > 3'b010);
  logic unusedOffLo;
  assign unusedOffLo = ^addrOff[1:0];
`else
  assign xferErr = 1'b0;
  logic unusedOffBits;
  assign unusedOffBits = ^{addrOff[31:ADDR_WIDTH+2], addrOff[1:0]};
`endif

  // The SRAM port is busy with the pending write in WR_DATA, so a read there must stall.
  assign issueRead = accept & ~HWrite & ~xferErr &
                     (state_q inside {IDLE, RD_DATA, ERR2});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      lane_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    lane_d  = lane_q;
    case (state_q)
      STALL_RD: state_d = RD_DATA;
      ERR1:     state_d = ERR2;
      default: begin
        state_d = IDLE;
        if (accept) begin
          if (xferErr) begin
            state_d = ERR1;
          end else begin
            addr_d  = wordAddr;
            write_d = HWrite;
            size_d  = HSize;
            lane_d  = HAddress[1:0];
            if (HWrite)                 state_d = WR_DATA;
            else if (state_q == WR_DATA) state_d = STALL_RD;
            else                         state_d = RD_DATA;
          end
        end
      end
    endcase
  end

  // Sizes above word fall into the word lane pattern.
  always_comb begin
    case (size_q)
      3'b000:  wrEnables = 4'b0001 << lane_q;
      3'b001:  wrEnables = lane_q[1] ? 4'b1100 : 4'b0011;
      default: wrEnables = 4'b1111;
    endcase
  end

  always_comb begin
    HReadyOut  = 1'b1;
    HResp      = 2'b00;
    HRead_data = '0;
    IM_CS      = 1'b0;
    IM_WE      = 4'b0000;
    IM_A       = '0;
    IM_DI      = '0;
    // Outputs are held quiet while reset is low so an interrupted write never reaches the SRAM.
    if (rst) begin
      case (state_q)
        RD_DATA: HRead_data = IM_DO;
        WR_DATA: begin
          IM_CS = 1'b1;
          IM_WE = wrEnables & {4{write_q}};
          IM_A  = addr_q;
          IM_DI = HWrite_data;
        end
        STALL_RD: begin
          HReadyOut = 1'b0;
          IM_CS     = 1'b1;
          IM_A      = addr_q;
        end
`ifdef IM_AHB_SLAVE_ERR_EN
        ERR1: begin
          HReadyOut = 1'b0;
          HResp     = 2'b01;
        end
        ERR2: HResp = 2'b01;
`endif
        default: ;
      endcase
      if (issueRead) begin
        IM_CS = 1'b1;
        IM_WE = 4'b0000;
        IM_A  = wordAddr;
      end
    end
  end

endmodule

// File: tb/tb_im_ahb_slave.sv
// Directed bench for im_ahb_slave with a behavioural SRAM; checks both IM_AHB_SLAVE_ERR_EN builds.
module tb_im_ahb_slave;

  localparam int AW = 14;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] SZ_B      = 3'b000;
  localparam logic [2:0] SZ_H      = 3'b001;
  localparam logic [2:0] SZ_W      = 3'b010;

  logic          clk = 1'b0;
  logic          rst;
  logic          HSel;
  logic [31:0]   HAddress;
  logic [1:0]    HTrans;
  logic          HWrite;
  logic [2:0]    HSize;
  logic [31:0]   HWrite_data;
  logic          HReady;
  logic          HReadyOut;
  logic [1:0]    HResp;
  logic [31:0]   HRead_data;
  logic          IM_CS;
  logic [3:0]    IM_WE;
  logic [AW-1:0] IM_A;
  logic [31:0]   IM_DI;
  logic [31:0]   IM_DO;

  int compCount = 0;
  int errCount  = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // Single slave on the bus, so the bus ready is this slave's ready.
  assign HReady = HReadyOut;

  im_ahb_slave #(
    .BASE_ADDR (32'h0000_0000),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .HSel       (HSel),
    .HAddress   (HAddress),
    .HTrans     (HTrans),
    .HWrite     (HWrite),
    .HSize      (HSize),
    .HWrite_data(HWrite_data),
    .HReady     (HReady),
    .HReadyOut  (HReadyOut),
    .HResp      (HResp),
    .HRead_data (HRead_data),
    .IM_CS      (IM_CS),
    .IM_WE      (IM_WE),
    .IM_A       (IM_A),
    .IM_DI      (IM_DI),
    .IM_DO      (IM_DO)
  );

  // Synchronous SRAM: byte-lane writes, read data one cycle after the read is issued.
  always @(posedge clk) begin
    if (IM_CS) begin
      if (IM_WE == 4'b0000) begin
        IM_DO <= mem[IM_A];
      end else begin
        for (int b = 0; b < 4; b++)
          if (IM_WE[b]) mem[IM_A][8*b +: 8] = IM_DI[8*b +: 8];
      end
    end
  end

  task automatic applyStimulus(input logic rstN, input logic sel, input logic [1:0] trans,
                               input logic write, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    rst         = rstN;
    HSel        = sel;
    HTrans      = trans;
    HWrite      = write;
    HSize       = size;
    HAddress    = addr;
    HWrite_data = wdata;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b0; HSel = 1'b0; HTrans = TR_IDLE; HWrite = 1'b0;
    HSize = SZ_W; HAddress = '0; HWrite_data = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[14'h040] = 32'h1111_0100;
    mem[14'h041] = 32'h2222_0104;
    mem[14'h042] = 32'h3333_0108;
    mem[14'h043] = 32'h4444_010C;
    mem[14'h008] = 32'hCAFE_F00D;

    // Reset state
    applyStimulus(0, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    applyStimulus(0, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("rst_readyout", 32'(HReadyOut), 32'h1);
    checkOutput("rst_resp",     32'(HResp),     32'h0);
    checkOutput("rst_rdata",    HRead_data,     32'h0);
    checkOutput("rst_cs",       32'(IM_CS),     32'h0);
    checkOutput("rst_we",       32'(IM_WE),     32'h0);
    checkOutput("rst_a",        32'(IM_A),      32'h0);
    checkOutput("rst_di",       IM_DI,          32'h0);

    // Word write then read-after-write with one stall cycle
    applyStimulus(1, 1, TR_NONSEQ, 1, SZ_W, 32'h40, 32'h0);
    checkOutput("w40_addr_cs",    32'(IM_CS),     32'h0);
    checkOutput("w40_addr_ready", 32'(HReadyOut), 32'h1);
    applyStimulus(1, 1, TR_NONSEQ, 0, SZ_W, 32'h40, 32'hDEAD_BEEF);
    checkOutput("w40_data_cs",    32'(IM_CS),     32'h1);
    checkOutput("w40_data_we",    32'(IM_WE),     32'hF);
    checkOutput("w40_data_a",     32'(IM_A),      32'h010);
    checkOutput("w40_data_di",    IM_DI,          32'hDEAD_BEEF);
    checkOutput("w40_data_ready", 32'(HReadyOut), 32'h1);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("raw_stall_ready", 32'(HReadyOut), 32'h0);
    checkOutput("raw_stall_cs",    32'(IM_CS),     32'h1);
    checkOutput("raw_stall_we",    32'(IM_WE),     32'h0);
    checkOutput("raw_stall_a",     32'(IM_A),      32'h010);
    checkOutput("raw_stall_rdata", HRead_data,     32'h0);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("raw_rd_ready", 32'(HReadyOut), 32'h1);
    checkOutput("raw_rd_rdata", HRead_data,     32'hDEAD_BEEF);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("idle_rdata", HRead_data, 32'h0);
    checkOutput("idle_cs",    32'(IM_CS), 32'h0);

    // Word write, back-to-back byte write to lane 3, then read back
    applyStimulus(1, 1, TR_NONSEQ, 1, SZ_W, 32'h40, 32'h0);
    applyStimulus(1, 1, TR_NONSEQ, 1, SZ_B, 32'h43, 32'h1122_3344);
    checkOutput("w40b_word_we", 32'(IM_WE), 32'hF);
    checkOutput("w40b_word_di", IM_DI,      32'h1122_3344);
    applyStimulus(1, 1, TR_NONSEQ, 0, SZ_W, 32'h40, 32'hA500_0000);
    checkOutput("b43_we",    32'(IM_WE),     32'h8);
    checkOutput("b43_a",     32'(IM_A),      32'h010);
    checkOutput("b43_di",    IM_DI,          32'hA500_0000);
    checkOutput("b43_ready", 32'(HReadyOut), 32'h1);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("b43_stall_ready", 32'(HReadyOut), 32'h0);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("b43_rdata", HRead_data, 32'hA522_3344);

    // Half-word writes to both halves of word 0x44
    applyStimulus(1, 1, TR_NONSEQ, 1, SZ_H, 32'h46, 32'h0);
    applyStimulus(1, 1, TR_NONSEQ, 1, SZ_H, 32'h44, 32'hBEEF_0000);
    checkOutput("h46_we", 32'(IM_WE), 32'hC);
    checkOutput("h46_a",  32'(IM_A),  32'h011);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0000_CAFE);
    checkOutput("h44_we", 32'(IM_WE), 32'h3);
    checkOutput("h44_a",  32'(IM_A),  32'h011);
    applyStimulus(1, 1, TR_NONSEQ, 0, SZ_W, 32'h44, 32'h0);
    checkOutput("r44_cs", 32'(IM_CS), 32'h1);
    checkOutput("r44_a",  32'(IM_A),  32'h011);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("r44_rdata", HRead_data, 32'hBEEF_CAFE);

    // Four pipelined reads 0x100..0x10C
    applyStimulus(1, 1, TR_NONSEQ, 0, SZ_W, 32'h100, 32'h0);
    checkOutput("seq0_cs",    32'(IM_CS),     32'h1);
    checkOutput("seq0_we",    32'(IM_WE),     32'h0);
    checkOutput("seq0_a",     32'(IM_A),      32'h040);
    checkOutput("seq0_ready", 32'(HReadyOut), 32'h1);
    applyStimulus(1, 1, TR_SEQ, 0, SZ_W, 32'h104, 32'h0);
    checkOutput("seq1_ready", 32'(HReadyOut), 32'h1);
    checkOutput("seq1_rdata", HRead_data,     32'h1111_0100);
    checkOutput("seq1_a",     32'(IM_A),      32'h041);
    applyStimulus(1, 1, TR_SEQ, 0, SZ_W, 32'h108, 32'h0);
    checkOutput("seq2_ready", 32'(HReadyOut), 32'h1);
    checkOutput("seq2_rdata", HRead_data,     32'h2222_0104);
    applyStimulus(1, 1, TR_SEQ, 0, SZ_W, 32'h10C, 32'h0);
    checkOutput("seq3_ready", 32'(HReadyOut), 32'h1);
    checkOutput("seq3_rdata", HRead_data,     32'h3333_0108);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("seq4_ready", 32'(HReadyOut), 32'h1);
    checkOutput("seq4_rdata", HRead_data,     32'h4444_010C);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("seq_end_rdata", HRead_data, 32'h0);

    // BUSY is answered OKAY with no SRAM access
    applyStimulus(1, 1, TR_BUSY, 0, SZ_W, 32'h100, 32'h0);
    checkOutput("busy_resp",  32'(HResp),     32'h0);
    checkOutput("busy_ready", 32'(HReadyOut), 32'h1);
    checkOutput("busy_cs",    32'(IM_CS),     32'h0);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("busy_next_ready", 32'(HReadyOut), 32'h1);
    checkOutput("busy_next_rdata", HRead_data,     32'h0);

    // Read just past the 64 KB window
    applyStimulus(1, 1, TR_NONSEQ, 0, SZ_W, 32'h0001_0000, 32'h0);
`ifdef IM_AHB_SLAVE_ERR_EN
    checkOutput("oor_addr_cs", 32'(IM_CS), 32'h0);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("oor_err1_ready", 32'(HReadyOut), 32'h0);
    checkOutput("oor_err1_resp",  32'(HResp),     32'h1);
    checkOutput("oor_err1_cs",    32'(IM_CS),     32'h0);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("oor_err2_ready", 32'(HReadyOut), 32'h1);
    checkOutput("oor_err2_resp",  32'(HResp),     32'h1);
    checkOutput("oor_err2_cs",    32'(IM_CS),     32'h0);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("oor_idle_resp", 32'(HResp), 32'h0);
`else
    checkOutput("wrap_addr_cs", 32'(IM_CS), 32'h1);
    checkOutput("wrap_addr_a",  32'(IM_A),  32'h0);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("wrap_ready", 32'(HReadyOut), 32'h1);
    checkOutput("wrap_resp",  32'(HResp),     32'h0);
    checkOutput("wrap_rdata", HRead_data,     32'h0);
`endif

    // Reset during the data phase of a write to 0x20 abandons the write
    applyStimulus(1, 1, TR_NONSEQ, 1, SZ_W, 32'h20, 32'h0);
    applyStimulus(0, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h1234_5678);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h1234_5678);
    checkOutput("rstw_we",    32'(IM_WE),     32'h0);
    checkOutput("rstw_ready", 32'(HReadyOut), 32'h1);
    checkOutput("rstw_cs",    32'(IM_CS),     32'h0);
    applyStimulus(1, 1, TR_NONSEQ, 0, SZ_W, 32'h20, 32'h0);
    checkOutput("rstw_rd_a", 32'(IM_A), 32'h008);
    applyStimulus(1, 0, TR_IDLE, 0, SZ_W, 32'h0, 32'h0);
    checkOutput("rstw_rdata", HRead_data, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
